mem_bus_arbiter: RTL and testbench

- Shares one single-outstanding memory bus between the instruction-fetch port and the MEM-stage data port.
- Sequences each bus transaction through an address handshake and then a data handshake.
- Drives per-port stall signals into the pipeline stall vector and returns read data.
- Honours the pipeline `exception` flush: aborts or discards instruction fetches and data reads that are in flight.

---
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: groups the fetch port, the MEM-stage data port and the
// single-outstanding memory bus into one bundle.
// The master modport is the arbiter's view; the slave modport is the view of
// everything around it (pipeline ports and bus slave).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic                inst_req;
  logic [ADDR_W-1:0]   inst_addr;
  logic [DATA_W-1:0]   inst_rdata;
  logic                inst_valid;
  logic                inst_stall;

  // MEM-stage data port
  logic                data_req;
  logic                data_wr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W-1:0]   data_rdata;
  logic                data_valid;
  logic                data_stall;

  // Memory bus
  logic                bus_req;
  logic                bus_wr;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_addr_ok;
  logic                bus_data_ok;
  logic [DATA_W-1:0]   bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_valid, inst_stall,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_valid, data_stall,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_valid, inst_stall,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_valid, data_stall,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory bus between the
// instruction-fetch port and the MEM-stage data port. Each transaction runs an
// address handshake, then a data handshake, then a one-cycle RESP pulse.
// A pipeline exception aborts a transaction still in its address phase and
// discards the result of one already in its data phase.
// Optional feature: define ARB_WBUF_EN to add a one-entry posted write buffer.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exception,
  mem_bus_arbiter_if.master   bus_if
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, RESP
`ifdef ARB_WBUF_EN
    , W_ADDR, W_DATA
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                discard_q, discard_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_wr_q, bus_wr_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_valid_q, inst_valid_d;
  logic                data_valid_q, data_valid_d;
`ifdef ARB_WBUF_EN
  logic                wbuf_full_q, wbuf_full_d;
  logic [ADDR_W-1:0]   wbuf_addr_q, wbuf_addr_d;
  logic [DATA_W-1:0]   wbuf_wdata_q, wbuf_wdata_d;
  logic [STRB_W-1:0]   wbuf_wstrb_q, wbuf_wstrb_d;
`endif

  // Next-state, bus register and response register logic for the arbiter FSM
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
`ifdef ARB_WBUF_EN
    wbuf_full_d  = wbuf_full_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_wdata_d = wbuf_wdata_q;
    wbuf_wstrb_d = wbuf_wstrb_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_WBUF_EN
        if (wbuf_full_q) begin
          state_d     = W_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b1;
          bus_addr_d  = wbuf_addr_q;
          bus_wdata_d = wbuf_wdata_q;
          bus_wstrb_d = wbuf_wstrb_q;
        end else if (bus_if.data_req && bus_if.data_wr) begin
          wbuf_full_d  = 1'b1;
          wbuf_addr_d  = bus_if.data_addr;
          wbuf_wdata_d = bus_if.data_wdata;
          wbuf_wstrb_d = bus_if.data_wstrb;
          state_d      = RESP;
          data_valid_d = 1'b1;
        end else
`endif
        if (bus_if.data_req) begin
          state_d     = D_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = bus_if.data_wr;
          bus_addr_d  = bus_if.data_addr;
          bus_wdata_d = bus_if.data_wdata;
          bus_wstrb_d = bus_if.data_wstrb;
        end else if (bus_if.inst_req) begin
          state_d     = I_ADDR;
          bus_req_d   = 1'b1;
          bus_wr_d    = 1'b0;
          bus_addr_d  = bus_if.inst_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end
      end
      I_ADDR, D_ADDR: begin
        if (bus_req_q && bus_if.bus_addr_ok) begin
          state_d   = (state_q == D_ADDR) ? D_DATA : I_DATA;
          bus_req_d = 1'b0;
          if (exception) discard_d = 1'b1;
        end else if (exception) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      I_DATA, D_DATA: begin
        if (bus_if.bus_data_ok) begin
          if (discard_q || exception) begin
            state_d   = IDLE;
            discard_d = 1'b0;
          end else begin
            state_d = RESP;
            if (state_q == D_DATA) begin
              data_rdata_d = bus_if.bus_rdata;
              data_valid_d = 1'b1;
            end else begin
              inst_rdata_d = bus_if.bus_rdata;
              inst_valid_d = 1'b1;
            end
          end
        end else if (exception) begin
          discard_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
`ifdef ARB_WBUF_EN
      W_ADDR: begin
        if (bus_req_q && bus_if.bus_addr_ok) begin
          state_d   = W_DATA;
          bus_req_d = 1'b0;
        end
      end
      W_DATA: begin
        if (bus_if.bus_data_ok) begin
          state_d     = IDLE;
          wbuf_full_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
`ifdef ARB_WBUF_EN
      wbuf_full_q  <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_wdata_q <= '0;
      wbuf_wstrb_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
`ifdef ARB_WBUF_EN
      wbuf_full_q  <= wbuf_full_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_wdata_q <= wbuf_wdata_d;
      wbuf_wstrb_q <= wbuf_wstrb_d;
`endif
    end
  end

  assign bus_if.bus_req    = bus_req_q;
  assign bus_if.bus_wr     = bus_wr_q;
  assign bus_if.bus_wstrb  = bus_wstrb_q;
  assign bus_if.bus_addr   = bus_addr_q;
  assign bus_if.bus_wdata  = bus_wdata_q;
  assign bus_if.inst_rdata = inst_rdata_q;
  assign bus_if.data_rdata = data_rdata_q;
  assign bus_if.inst_valid = inst_valid_q;
  assign bus_if.data_valid = data_valid_q;

  // Stalls hold each pipeline stage until its own completion pulse
  assign bus_if.inst_stall = bus_if.inst_req & ~inst_valid_q;
  assign bus_if.data_stall = bus_if.data_req & ~data_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed, cycle-accurate bench for mem_bus_arbiter.
// Each task drives one scenario; cycle n starts at posedge+1, where the
// registered outputs of cycle n are sampled and inputs for cycle n are driven.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  logic exception;
  int   checks;
  int   passes;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .exception (exception),
    .bus_if    (bus_if)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exception          = 1'b0;
    bus_if.inst_req    = 1'b0;
    bus_if.inst_addr   = '0;
    bus_if.data_req    = 1'b0;
    bus_if.data_wr     = 1'b0;
    bus_if.data_wstrb  = '0;
    bus_if.data_addr   = '0;
    bus_if.data_wdata  = '0;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL rst_bus_req: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_wr !== 1'b0) $display("[TB] FAIL rst_bus_wr: got %b want 0", bus_if.bus_wr); else passes++;
    checks++; if (bus_if.bus_wstrb !== 4'h0) $display("[TB] FAIL rst_bus_wstrb: got %h want 0", bus_if.bus_wstrb); else passes++;
    checks++; if (bus_if.bus_addr !== 32'h0) $display("[TB] FAIL rst_bus_addr: got %h want 0", bus_if.bus_addr); else passes++;
    checks++; if (bus_if.bus_wdata !== 32'h0) $display("[TB] FAIL rst_bus_wdata: got %h want 0", bus_if.bus_wdata); else passes++;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL rst_inst_valid: got %b want 0", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL rst_data_valid: got %b want 0", bus_if.data_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h0) $display("[TB] FAIL rst_inst_rdata: got %h want 0", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.data_rdata !== 32'h0) $display("[TB] FAIL rst_data_rdata: got %h want 0", bus_if.data_rdata); else passes++;
    rst = 1'b0;
    step();
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL idle_no_req: got %b want 0", bus_if.bus_req); else passes++;
  endtask

  task automatic test_zero_wait_fetch();
    // cycle 0: fetch request seen in IDLE
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00000;
    #1;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL zw_stall_c0: got %b want 1", bus_if.inst_stall); else passes++;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL zw_bus_req_c0: got %b want 0", bus_if.bus_req); else passes++;
    // cycle 1: address phase
    step();
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL zw_bus_req_c1: got %b want 1", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'hBFC00000) $display("[TB] FAIL zw_bus_addr_c1: got %h want bfc00000", bus_if.bus_addr); else passes++;
    checks++; if (bus_if.bus_wr !== 1'b0) $display("[TB] FAIL zw_bus_wr_c1: got %b want 0", bus_if.bus_wr); else passes++;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL zw_stall_c1: got %b want 1", bus_if.inst_stall); else passes++;
    bus_if.bus_addr_ok = 1'b1;
    // cycle 2: data phase
    step();
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL zw_bus_req_c2: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL zw_valid_c2: got %b want 0", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL zw_stall_c2: got %b want 1", bus_if.inst_stall); else passes++;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h3C08BFAF;
    // cycle 3: RESP pulse, request still held
    step();
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.inst_valid !== 1'b1) $display("[TB] FAIL zw_valid_c3: got %b want 1", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h3C08BFAF) $display("[TB] FAIL zw_rdata_c3: got %h want 3c08bfaf", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.inst_stall !== 1'b0) $display("[TB] FAIL zw_stall_c3: got %b want 0", bus_if.inst_stall); else passes++;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL zw_dvalid_c3: got %b want 0", bus_if.data_valid); else passes++;
    // cycle 4: back to IDLE; RESP must not have re-granted the held request
    step();
    bus_if.inst_req = 1'b0;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL zw_valid_c4: got %b want 0", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL zw_no_regrant_c4: got %b want 0", bus_if.bus_req); else passes++;
    step();
  endtask

  task automatic test_contention();
    // cycle 0: both ports request; data must win
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00010;
    bus_if.data_req  = 1'b1;
    bus_if.data_wr   = 1'b0;
    bus_if.data_addr = 32'h80001000;
    step();
    // cycle 1
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL ct_bus_req_c1: got %b want 1", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'h80001000) $display("[TB] FAIL ct_bus_addr_c1: got %h want 80001000", bus_if.bus_addr); else passes++;
    checks++; if (bus_if.bus_wr !== 1'b0) $display("[TB] FAIL ct_bus_wr_c1: got %b want 0", bus_if.bus_wr); else passes++;
    bus_if.bus_addr_ok = 1'b1;
    step();
    // cycle 2
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'hDEADBEEF;
    #1;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL ct_istall_c2: got %b want 1", bus_if.inst_stall); else passes++;
    checks++; if (bus_if.data_stall !== 1'b1) $display("[TB] FAIL ct_dstall_c2: got %b want 1", bus_if.data_stall); else passes++;
    step();
    // cycle 3: data RESP
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.data_valid !== 1'b1) $display("[TB] FAIL ct_dvalid_c3: got %b want 1", bus_if.data_valid); else passes++;
    checks++; if (bus_if.data_rdata !== 32'hDEADBEEF) $display("[TB] FAIL ct_drdata_c3: got %h want deadbeef", bus_if.data_rdata); else passes++;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL ct_ivalid_c3: got %b want 0", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h3C08BFAF) $display("[TB] FAIL ct_irdata_kept_c3: got %h want 3c08bfaf", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL ct_istall_c3: got %b want 1", bus_if.inst_stall); else passes++;
    checks++; if (bus_if.data_stall !== 1'b0) $display("[TB] FAIL ct_dstall_c3: got %b want 0", bus_if.data_stall); else passes++;
    step();
    // cycle 4: IDLE grants inst
    bus_if.data_req = 1'b0;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL ct_bus_req_c4: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.inst_stall !== 1'b1) $display("[TB] FAIL ct_istall_c4: got %b want 1", bus_if.inst_stall); else passes++;
    step();
    // cycle 5: inst address phase
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL ct_bus_req_c5: got %b want 1", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'hBFC00010) $display("[TB] FAIL ct_bus_addr_c5: got %h want bfc00010", bus_if.bus_addr); else passes++;
    bus_if.bus_addr_ok = 1'b1;
    step();
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h11112222;
    step();
    // cycle 7: inst RESP
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.inst_valid !== 1'b1) $display("[TB] FAIL ct_ivalid_c7: got %b want 1", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h11112222) $display("[TB] FAIL ct_irdata_c7: got %h want 11112222", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.data_rdata !== 32'hDEADBEEF) $display("[TB] FAIL ct_drdata_kept_c7: got %h want deadbeef", bus_if.data_rdata); else passes++;
    step();
    bus_if.inst_req = 1'b0;
    step();
  endtask

  task automatic test_flush_i_data();
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00020;
    step();
    // cycle 1: addr handshake
    bus_if.bus_addr_ok = 1'b1;
    step();
    // cycle 2: I_DATA, flush
    bus_if.bus_addr_ok = 1'b0;
    exception = 1'b1;
    step();
    exception       = 1'b0;
    bus_if.inst_req = 1'b0;
    // cycles 3..4: slave still busy
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL fd_valid_wait%0d: got %b want 0", i, bus_if.inst_valid); else passes++;
      step();
    end
    // cycle 5: late data_ok must be discarded
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h55555555;
    step();
    // cycle 6: IDLE, no pulse, rdata unchanged; issue a new fetch
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL fd_valid_c6: got %b want 0", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h11112222) $display("[TB] FAIL fd_rdata_kept_c6: got %h want 11112222", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL fd_bus_req_c6: got %b want 0", bus_if.bus_req); else passes++;
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00030;
    step();
    // cycle 7: new fetch granted straight from IDLE
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL fd_regrant_c7: got %b want 1", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'hBFC00030) $display("[TB] FAIL fd_addr_c7: got %h want bfc00030", bus_if.bus_addr); else passes++;
    bus_if.bus_addr_ok = 1'b1;
    step();
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h66666666;
    step();
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.inst_valid !== 1'b1) $display("[TB] FAIL fd_valid_c9: got %b want 1", bus_if.inst_valid); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h66666666) $display("[TB] FAIL fd_rdata_c9: got %h want 66666666", bus_if.inst_rdata); else passes++;
    step();
    bus_if.inst_req = 1'b0;
    step();
  endtask

  task automatic test_flush_i_addr();
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00040;
    step();
    // cycle 1: slave not ready
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL fa_bus_req_c1: got %b want 1", bus_if.bus_req); else passes++;
    step();
    // cycle 2: still waiting, flush
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL fa_bus_req_c2: got %b want 1", bus_if.bus_req); else passes++;
    exception = 1'b1;
    step();
    // cycle 3: request withdrawn
    exception       = 1'b0;
    bus_if.inst_req = 1'b0;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL fa_bus_req_c3: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL fa_valid_c3: got %b want 0", bus_if.inst_valid); else passes++;
    step();
    checks++; if (bus_if.inst_valid !== 1'b0) $display("[TB] FAIL fa_valid_c4: got %b want 0", bus_if.inst_valid); else passes++;
    bus_if.inst_req  = 1'b1;
    bus_if.inst_addr = 32'hBFC00050;
    step();
    // cycle 5: back in service
    checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL fa_regrant_c5: got %b want 1", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'hBFC00050) $display("[TB] FAIL fa_addr_c5: got %h want bfc00050", bus_if.bus_addr); else passes++;
    bus_if.bus_addr_ok = 1'b1;
    step();
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'hA5A5A5A5;
    step();
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.inst_rdata !== 32'hA5A5A5A5) $display("[TB] FAIL fa_rdata_c7: got %h want a5a5a5a5", bus_if.inst_rdata); else passes++;
    step();
    bus_if.inst_req = 1'b0;
    step();
  endtask

  task automatic test_wait_write();
    bus_if.data_req   = 1'b1;
    bus_if.data_wr    = 1'b1;
    bus_if.data_wstrb = 4'b0011;
    bus_if.data_addr  = 32'h80000004;
    bus_if.data_wdata = 32'h00001234;
    step();
    // cycles 1..4: bus_req held with stable payload; addr_ok arrives in cycle 4
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus_if.bus_req !== 1'b1) $display("[TB] FAIL ww_bus_req_c%0d: got %b want 1", i, bus_if.bus_req); else passes++;
      checks++; if (bus_if.bus_addr !== 32'h80000004) $display("[TB] FAIL ww_addr_c%0d: got %h want 80000004", i, bus_if.bus_addr); else passes++;
      checks++; if (bus_if.bus_wdata !== 32'h00001234) $display("[TB] FAIL ww_wdata_c%0d: got %h want 00001234", i, bus_if.bus_wdata); else passes++;
      checks++; if ({bus_if.bus_wr, bus_if.bus_wstrb} !== 5'b1_0011) $display("[TB] FAIL ww_wr_strb_c%0d: got %b want 10011", i, {bus_if.bus_wr, bus_if.bus_wstrb}); else passes++;
      bus_if.bus_addr_ok = (i == 4);
      step();
    end
    // cycle 5: data phase
    bus_if.bus_addr_ok = 1'b0;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL ww_bus_req_c5: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL ww_valid_c5: got %b want 0", bus_if.data_valid); else passes++;
    bus_if.bus_data_ok = 1'b1;
    step();
    // cycle 6: completion
    bus_if.bus_data_ok = 1'b0;
    checks++; if (bus_if.data_valid !== 1'b1) $display("[TB] FAIL ww_valid_c6: got %b want 1", bus_if.data_valid); else passes++;
    checks++; if (bus_if.data_stall !== 1'b0) $display("[TB] FAIL ww_stall_c6: got %b want 0", bus_if.data_stall); else passes++;
    step();
    bus_if.data_req = 1'b0;
    bus_if.data_wr  = 1'b0;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL ww_valid_c7: got %b want 0", bus_if.data_valid); else passes++;
    step();
  endtask

  task automatic test_reset_d_data();
    bus_if.data_req  = 1'b1;
    bus_if.data_wr   = 1'b0;
    bus_if.data_addr = 32'h80002000;
    step();
    bus_if.bus_addr_ok = 1'b1;
    step();
    // cycle 2: D_DATA, reset pulse
    bus_if.bus_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    // cycle 3: everything cleared
    rst = 1'b0;
    bus_if.data_req = 1'b0;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL rd_bus_req_c3: got %b want 0", bus_if.bus_req); else passes++;
    checks++; if (bus_if.bus_addr !== 32'h0) $display("[TB] FAIL rd_bus_addr_c3: got %h want 0", bus_if.bus_addr); else passes++;
    checks++; if (bus_if.data_rdata !== 32'h0) $display("[TB] FAIL rd_drdata_c3: got %h want 0", bus_if.data_rdata); else passes++;
    checks++; if (bus_if.inst_rdata !== 32'h0) $display("[TB] FAIL rd_irdata_c3: got %h want 0", bus_if.inst_rdata); else passes++;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL rd_dvalid_c3: got %b want 0", bus_if.data_valid); else passes++;
    step();
    // cycle 4: stale data_ok must be ignored in IDLE
    bus_if.bus_data_ok = 1'b1;
    bus_if.bus_rdata   = 32'h77777777;
    step();
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    checks++; if (bus_if.data_valid !== 1'b0) $display("[TB] FAIL rd_dvalid_c5: got %b want 0", bus_if.data_valid); else passes++;
    checks++; if (bus_if.data_rdata !== 32'h0) $display("[TB] FAIL rd_drdata_c5: got %h want 0", bus_if.data_rdata); else passes++;
    checks++; if (bus_if.bus_req !== 1'b0) $display("[TB] FAIL rd_bus_req_c5: got %b want 0", bus_if.bus_req); else passes++;
    step();
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_zero_wait_fetch();
    test_contention();
    test_flush_i_data();
    test_flush_i_addr();
    test_wait_write();
    test_reset_d_data();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
